mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 114 +++++++++++
 tb/tb_mult_div.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// rtl/mult_div.sv - iterative 32x32 multiply / restoring divide unit with HI/LO registers
// Fixed 34-edge latency: one accept edge, 32 RUN iterations, one FIX (sign correction) edge.
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, next_state;
  logic [1:0]  op_q;
  logic [4:0]  cnt;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic        neg_res, neg_rem, div0;

  logic        a_s, b_s;
  logic [31:0] a_mag, b_mag;
  logic        is_div;
  logic [32:0] mul_sum, diff;
  logic        qbit;
  logic [31:0] rem_new;
  logic [63:0] acc_next, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Even op codes are the signed variants.
  assign a_s   = ~op[0] & in1[31];
  assign b_s   = ~op[0] & in2[31];
  assign a_mag = a_s ? -in1 : in1;
  assign b_mag = b_s ? -in2 : in2;

  assign is_div = op_q[1];

  // Multiply: acc = {partial, multiplier}; add multiplicand on acc[0], shift right.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);

  // Divide: acc = {remainder, quotient}; shift left, trial-subtract the divisor.
  assign diff    = acc[63:31] - {1'b0, opnd};
  assign qbit    = ~diff[32];
  assign rem_new = qbit ? diff[31:0] : acc[62:31];

  assign acc_next = is_div ? {rem_new, acc[30:0], qbit} : {mul_sum, acc[31:1]};

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = (neg_res & ~div0) ? -acc[31:0] : acc[31:0];
  assign rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (cnt == 5'd31) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      op_q    <= 2'd0;
      cnt     <= 5'd0;
      opnd    <= 32'd0;
      acc     <= 64'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            cnt     <= 5'd0;
            opnd    <= op[1] ? b_mag : a_mag;
            acc     <= {32'd0, op[1] ? a_mag : b_mag};
            neg_res <= a_s ^ b_s;
            neg_rem <= a_s;
            div0    <= (in2 == 32'd0);
          end else begin
            if (mthi) hi <= in1;
            if (mtlo) lo <= in1;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          hi <= is_div ? rem_fix : prod_fix[63:32];
          lo <= is_div ? quo_fix : prod_fix[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - directed self-checking bench for mult_div
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic [1:0]  op = '0;
  logic        start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mult_div dut (
    .clock(clock), .reset(reset), .in1(in1), .in2(in2), .op(op),
    .start(start), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Stimulus lives in the phase 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; in1 = a; in2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
  endtask

  task automatic wait_done();
    while (!done && edges < 80) begin
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0)  begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    issue(MULT, 32'hFFFFFFFD, 32'd7);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy got %b want 1", busy); end
    wait_done();
    n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL mult_latency got %0d want 34", edges); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_end got %b want 0", busy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_single got %b want 0", done); end
  endtask

  task automatic test_multu();
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", lo); end
    tick();
    issue(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done();
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mult_m1_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd1) begin n_fail++; $display("FAIL mult_m1_lo got %h want 1", lo); end
    tick();
  endtask

  task automatic test_div();
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_done();
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", hi); end
    tick();
    issue(DIVU, 32'd7, 32'd0);
    wait_done();
    n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL divz_latency got %0d want 34", edges); end
    n_checks++; if (hi !== 32'd7) begin n_fail++; $display("FAIL divz_hi got %h want 7", hi); end
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_lo got %h want ffffffff", lo); end
    tick();
    issue(DIV, 32'hFFFFFFF9, 32'd0);
    wait_done();
    n_checks++; if (hi !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL sdivz_hi got %h want fffffff9", hi); end
    n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sdivz_lo got %h want ffffffff", lo); end
    tick();
  endtask

  task automatic test_div_overflow();
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL ovf_latency got %0d want 34", edges); end
    n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL ovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ovf_hi got %h want 0", hi); end
    tick();
  endtask

  task automatic test_busy_ignore();
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    issue(DIVU, 32'd100, 32'd7);
    while (edges < 9) begin tick(); edges++; end
    op = MULTU; in1 = 32'hDEAD; in2 = 32'd3; start = 1'b1; mthi = 1'b1;
    tick(); edges++;
    start = 1'b0; mthi = 1'b0; in1 = 32'd55; in2 = 32'd66;
    n_checks++; if (hi !== hi0) begin n_fail++; $display("FAIL busy_hold_hi got %h want %h", hi, hi0); end
    n_checks++; if (lo !== lo0) begin n_fail++; $display("FAIL busy_hold_lo got %h want %h", lo, lo0); end
    wait_done();
    n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL busy_latency got %0d want 34", edges); end
    n_checks++; if (hi !== 32'd2)  begin n_fail++; $display("FAIL divu_hi got %h want 2", hi); end
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %h want 14", lo); end
    tick();
    in1 = 32'h1234; mtlo = 1'b1;
    tick();
    mtlo = 1'b0;
    n_checks++; if (lo !== 32'h1234) begin n_fail++; $display("FAIL mtlo_lo got %h want 1234", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL mtlo_hi got %h want 2", hi); end
  endtask

  task automatic test_moves();
    in1 = 32'hABCD; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    n_checks++; if (hi !== 32'hABCD) begin n_fail++; $display("FAIL both_hi got %h want abcd", hi); end
    n_checks++; if (lo !== 32'hABCD) begin n_fail++; $display("FAIL both_lo got %h want abcd", lo); end
    mthi = 1'b1;
    issue(MULTU, 32'd2, 32'd3);
    mthi = 1'b0;
    n_checks++; if (hi !== 32'hABCD) begin n_fail++; $display("FAIL start_wins_hi got %h want abcd", hi); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_wins_busy got %b want 1", busy); end
    wait_done();
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL start_wins_res_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd6) begin n_fail++; $display("FAIL start_wins_res_lo got %h want 6", lo); end
  endtask

  task automatic test_back_to_back();
    // done is high here; a start now must be accepted on the next edge.
    issue(DIV, 32'd20, 32'hFFFFFFFA);
    wait_done();
    n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL b2b_latency got %0d want 34", edges); end
    n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL b2b_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL b2b_hi got %h want 2", hi); end
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    issue(MULTU, 32'd5, 32'd5);
    while (edges < 19) begin tick(); edges++; end
    reset = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL abort_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL abort_lo got %h want 0", lo); end
    reset = 1'b1;
    issue(MULTU, 32'd9, 32'd9);
    seen = 0;
    while (edges < 33) begin
      tick(); edges++;
      if (done) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_stray_done got %0d want 0", seen); end
    wait_done();
    n_checks++; if (edges !== 34) begin n_fail++; $display("FAIL abort_restart_latency got %0d want 34", edges); end
    n_checks++; if (lo !== 32'd81) begin n_fail++; $display("FAIL abort_restart_lo got %h want 51", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL abort_restart_hi got %h want 0", hi); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_overflow();
    test_busy_ignore();
    test_moves();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
